// File: rtl/mult_share_arbiter.sv
// ============================================================================
// mult_share_arbiter : round-robin sharing of one WIDTH x WIDTH multiplier
// Rev 1.0
// ============================================================================
`default_nettype none

module mult_share_arbiter #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_left,
  input  logic [NUM_REQ*WIDTH-1:0] req_right,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [WIDTH-1:0]         resp_data,
  output logic [ID_W-1:0]          resp_id
);

  localparam logic [ID_W-1:0] C_LAST_ID = ID_W'(NUM_REQ - 1);

  logic              s1_valid_q, s1_valid_d;
  logic [ID_W-1:0]   s1_id_q,    s1_id_d;
  logic [WIDTH-1:0]  s1_left_q,  s1_left_d;
  logic [WIDTH-1:0]  s1_right_q, s1_right_d;
  logic              s2_valid_q, s2_valid_d;
  logic [ID_W-1:0]   s2_id_q,    s2_id_d;
  logic [WIDTH-1:0]  s2_data_q,  s2_data_d;
  logic [ID_W-1:0]   rr_ptr_q,   rr_ptr_d;

  logic              w_s2_adv;
  logic              w_s1_adv;
  logic              w_any;
  logic              w_hi_found;
  logic [ID_W-1:0]   w_hi_idx;
  logic [ID_W-1:0]   w_lo_idx;
  logic [ID_W-1:0]   w_grant;
  logic [WIDTH-1:0]  w_grant_left;
  logic [WIDTH-1:0]  w_grant_right;
  logic [WIDTH-1:0]  w_product;

  assign w_s2_adv  = !s2_valid_q || resp_ready;
  assign w_s1_adv  = !s1_valid_q || w_s2_adv;
  assign w_any     = |req_valid;
  assign w_product = s1_left_q * s1_right_q;

  // Round-robin: lowest valid index at or above rr_ptr, else lowest valid overall.
  always_comb begin
    w_hi_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        w_lo_idx = ID_W'(i);
        if (i >= int'(rr_ptr_q)) begin
          w_hi_found = 1'b1;
          w_hi_idx   = ID_W'(i);
        end
      end
    end
    w_grant = w_hi_found ? w_hi_idx : w_lo_idx;
  end

  always_comb begin
    req_ready     = '0;
    w_grant_left  = '0;
    w_grant_right = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant == ID_W'(i)) begin
        req_ready[i]  = w_any && w_s1_adv && reset_n;
        w_grant_left  = req_left[i*WIDTH +: WIDTH];
        w_grant_right = req_right[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_id_d    = s1_id_q;
    s1_left_d  = s1_left_q;
    s1_right_d = s1_right_q;
    s2_valid_d = s2_valid_q;
    s2_id_d    = s2_id_q;
    s2_data_d  = s2_data_q;
    rr_ptr_d   = rr_ptr_q;
    if (w_s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_id_d   = s1_id_q;
        s2_data_d = w_product;
      end
    end
    if (w_s1_adv) begin
      s1_valid_d = w_any;
      if (w_any) begin
        s1_id_d    = w_grant;
        s1_left_d  = w_grant_left;
        s1_right_d = w_grant_right;
        rr_ptr_d   = (w_grant == C_LAST_ID) ? '0 : w_grant + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_id_q    <= '0;
      s1_left_q  <= '0;
      s1_right_q <= '0;
      s2_valid_q <= 1'b0;
      s2_id_q    <= '0;
      s2_data_q  <= '0;
      rr_ptr_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_id_q    <= s1_id_d;
      s1_left_q  <= s1_left_d;
      s1_right_q <= s1_right_d;
      s2_valid_q <= s2_valid_d;
      s2_id_q    <= s2_id_d;
      s2_data_q  <= s2_data_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign resp_valid = s2_valid_q;
  assign resp_id    = s2_id_q;
  assign resp_data  = s2_data_q;

endmodule

`default_nettype wire

// File: tb/tb_mult_share_arbiter.sv
// ============================================================================
// tb_mult_share_arbiter : directed vectors for mult_share_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mult_share_arbiter;

  localparam int WIDTH   = 32;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                     clk;
  logic                     reset_n;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_left;
  logic [NUM_REQ*WIDTH-1:0] req_right;
  logic                     resp_valid;
  logic                     resp_ready;
  logic [WIDTH-1:0]         resp_data;
  logic [ID_W-1:0]          resp_id;

  int n_vec = 0;
  int n_err = 0;
  int granted;

  mult_share_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_left   (req_left),
    .req_right  (req_right),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r);
    req_left[i*WIDTH +: WIDTH]  = l;
    req_right[i*WIDTH +: WIDTH] = r;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // At most one requester may see ready in any cycle.
  always @(negedge clk) begin
    #2;
    chk("onehot", 64'($onehot0(req_ready)), 64'd1);
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    reset_n    = 1'b0;
    req_valid  = '0;
    req_left   = '0;
    req_right  = '0;
    resp_ready = 1'b1;
    @(negedge clk);
    tick();
    tick();
    #1;
    chk("rst_valid", resp_valid, 0);
    chk("rst_data",  resp_data,  0);
    chk("rst_id",    resp_id,    0);
    chk("rst_ready", req_ready,  0);

    // Single requester 2: 3*5
    reset_n = 1'b1;
    set_op(2, 32'd3, 32'd5);
    req_valid = 4'b0100;
    #1;
    chk("single_ready", req_ready, 4'b0100);
    tick();
    req_valid = 4'b0000;
    #1;
    chk("single_lat", resp_valid, 0);
    tick();
    #1;
    chk("single_valid", resp_valid, 1);
    chk("single_data",  resp_data,  15);
    chk("single_id",    resp_id,    2);
    tick();
    #1;
    chk("single_drain", resp_valid, 0);
    chk("single_hold",  resp_data,  15);

    // Round robin from a fresh pointer, all four valid
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) set_op(i, 32'(i + 1), 32'd10);
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("rr_ready", req_ready, 64'(1 << (k % 4)));
      if (k >= 2) begin
        chk("rr_valid", resp_valid, 1);
        chk("rr_id",    resp_id,    64'((k - 2) % 4));
        chk("rr_data",  resp_data,  64'(10 * ((k - 2) % 4 + 1)));
      end
      tick();
    end
    req_valid = 4'b0000;
    tick();
    tick();
    tick();

    // Backpressure: three requests, two fit
    resp_ready = 1'b0;
    set_op(0, 32'd2, 32'd3);
    set_op(1, 32'd4, 32'd5);
    set_op(2, 32'd6, 32'd7);
    req_valid = 4'b0111;
    #1;
    chk("bp_rdy0", req_ready, 4'b0001);
    tick();
    req_valid = 4'b0110;
    #1;
    chk("bp_rdy1", req_ready, 4'b0010);
    tick();
    req_valid = 4'b0100;
    #1;
    chk("bp_full_rdy", req_ready,  4'b0000);
    chk("bp_full_vld", resp_valid, 1);
    chk("bp_full_id",  resp_id,    0);
    chk("bp_full_dat", resp_data,  6);
    tick();
    #1;
    chk("bp_stall_rdy", req_ready, 4'b0000);
    chk("bp_stall_id",  resp_id,   0);
    chk("bp_stall_dat", resp_data, 6);
    resp_ready = 1'b1;
    #1;
    chk("bp_rdy2", req_ready, 4'b0100);
    tick();
    req_valid = 4'b0000;
    #1;
    chk("bp_drain1_vld", resp_valid, 1);
    chk("bp_drain1_id",  resp_id,    1);
    chk("bp_drain1_dat", resp_data,  20);
    tick();
    #1;
    chk("bp_drain2_id",  resp_id,   2);
    chk("bp_drain2_dat", resp_data, 42);
    tick();
    #1;
    chk("bp_empty", resp_valid, 0);

    // Truncation: pointer is 3, so requester 1 wins after wrap
    set_op(1, 32'hFFFF_FFFF, 32'd2);
    req_valid = 4'b0010;
    #1;
    chk("wrap_ready", req_ready, 4'b0010);
    tick();
    req_valid = 4'b0000;
    tick();
    #1;
    chk("wrap_data", resp_data, 32'hFFFF_FFFE);
    chk("wrap_id",   resp_id,   1);
    tick();

    // Fairness: requester 0 streams, requester 3 raises once
    set_op(0, 32'd1, 32'd1);
    set_op(3, 32'd9, 32'd9);
    req_valid = 4'b0001;
    #1;
    chk("fair_r0", req_ready, 4'b0001);
    tick();
    tick();
    req_valid = 4'b1001;
    granted = 0;
    for (int k = 0; k < NUM_REQ && granted == 0; k++) begin
      #1;
      if (req_ready[3]) granted = 1;
      tick();
    end
    chk("fair_grant3", granted, 1);
    req_valid = 4'b0001;
    #1;
    chk("fair_next", req_ready, 4'b0001);
    tick();
    #1;
    chk("fair_id",   resp_id,   3);
    chk("fair_data", resp_data, 81);
    req_valid = 4'b0000;
    tick();
    tick();
    tick();

    // Reset with both stages full
    resp_ready = 1'b0;
    set_op(0, 32'd7, 32'd7);
    set_op(1, 32'd8, 32'd8);
    req_valid = 4'b0011;
    tick();
    tick();
    tick();
    #1;
    chk("mid_full", resp_valid, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rdy_rst", req_ready, 0);
    tick();
    #1;
    chk("mid_valid", resp_valid, 0);
    chk("mid_data",  resp_data,  0);
    chk("mid_rdy",   req_ready,  0);
    reset_n    = 1'b1;
    req_valid  = 4'b0000;
    resp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      #1;
      chk("mid_stale", resp_valid, 0);
    end
    req_valid = 4'b1111;
    #1;
    chk("mid_ptr", req_ready, 4'b0001);
    req_valid = 4'b0000;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
- Time-shares one full-width combinational multiplier (left*right, truncated to WIDTH) among NUM_REQ requesters.
- Round-robin arbitration, a two-stage registered pipeline (operand register, then product register) and a single tagged response channel with backpressure.
- Sits between compute lanes and the single multiplier instance, so the multiplier is not replicated per lane.

Parameters:
- WIDTH, 32, operand/result width in bits.
- NUM_REQ, 4, number of requesters (2..16).
- ID_W, 2, width of requester tag; must satisfy 2**ID_W >= NUM_REQ.

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  synchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; at most one bit high per cycle.
- req_left  input  NUM_REQ*WIDTH  left operands, requester i at bits [i*WIDTH +: WIDTH].
- req_right  input  NUM_REQ*WIDTH  right operands, same packing.
- resp_valid  output  1  product valid.
- resp_ready  input  1  consumer accepts product.
- resp_data  output  WIDTH  product (left*right)[WIDTH-1:0].
- resp_id  output  ID_W  index of the requester that issued the product.

Behaviour:
- Reset: with reset_n low at a rising edge, clear all valid bits in S1 and S2 and set the round-robin pointer rr_ptr to 0. After reset: resp_valid=0, resp_data=0, resp_id=0, req_ready=0. Reset wins over any handshake in the same cycle. Reset mid-operation discards in-flight ops with no response.
- S1 (operand stage): holds s1_valid, s1_id, s1_left and s1_right.
- S2 (product stage): drives resp_valid, resp_id and resp_data.
- s2_adv = !resp_valid || resp_ready.
- s1_adv = !s1_valid || s2_adv.
- Grant: combinational. Scan requesters starting at index rr_ptr, wrapping modulo NUM_REQ. The first i with req_valid[i]=1 is the grant. req_ready[i] = (i == grant) && s1_adv. req_ready must not depend on resp_ready when S1 is empty.
- Request accept: when req_valid[g] && req_ready[g], S1 loads {1, g, left_g, right_g} and rr_ptr becomes (g+1) mod NUM_REQ. Otherwise rr_ptr holds. If s1_adv is high with no request, s1_valid becomes 0.
- S1 to S2: when s1_adv && s1_valid, S2 loads resp_data = (s1_left*s1_right)[WIDTH-1:0] and resp_id = s1_id, with resp_valid=1.
- Response accept: resp_ready high with resp_valid high and S1 empty clears resp_valid. resp_data and resp_id keep their last values while resp_valid=0.
- Latency: accept at edge N gives resp_valid=1 after edge N+1, provided the pipeline is not stalled.
- Throughput: one op per cycle when resp_ready is held high.
- Full: both stages valid and resp_ready=0. All req_ready=0, nothing changes, and S2 outputs stay stable.
- Simultaneous resp accept and new request in the same cycle: both advance, with no bubble.
- Fairness: a requester holding req_valid high is granted within NUM_REQ accepts.
- Requesters must hold valid and operands stable until accepted. The arbiter does not latch requests that are not granted.
- Arithmetic: unsigned, truncated to WIDTH. Overflow wraps silently.
- Protocol invariant: $onehot0(req_ready).

Test Plan:
- Reset mid-stream: fill both stages, assert reset_n=0 for one cycle. Required: resp_valid=0, req_ready=0 and rr_ptr=0 the next cycle, and no stale response afterwards.
- Single requester: req 2 issues 3*5 with resp_ready=1. Required: resp_valid=1 two edges after reset release plus accept, with resp_data=15 and resp_id=2.
- All four requesters valid continuously, resp_ready=1. Required: grants cycle 0,1,2,3,0,… one per cycle, and resp_id follows the same order two cycles later.
- Backpressure: resp_ready=0 while 3 requests arrive. Required: exactly 2 accepted, req_ready all 0 after that, and resp_data/resp_id stable. Release resp_ready: both products drain in order, then the third request is accepted.
- Wrap and truncation, WIDTH=32: 0xFFFF_FFFF*2. Required: resp_data=0xFFFF_FFFE.
- Fairness: requester 0 always valid, requester 3 raises valid once. Required: requester 3 is granted within 4 accepts and never starves.
